// File: rtl/activation_pkg.sv
// Shared encodings for the activation pipeline: per-beat function select and shift amounts.
// Pure declarations; no latency, no flow control.
package activation_pkg;

  typedef enum logic [1:0] {
    MODE_SIGMOID = 2'd0,
    MODE_RELU    = 2'd1,
    MODE_LEAKY   = 2'd2,
    MODE_BYPASS  = 2'd3
  } mode_e;

  localparam int SIG_SHIFT   = 2;
  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/act_lane.sv
// One lane of the activation function: sample and mode in, result and clamp flag out.
// Purely combinational (zero latency); no flow control.
module act_lane
  import activation_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 11
) (
  input  logic signed [WIDTH-1:0] x,
  input  mode_e                   mode,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);

  localparam int ONE_I = 1 << FRAC_BITS;
  localparam logic signed [WIDTH+1:0] ONE  = ONE_I[WIDTH+1:0];
  localparam logic signed [WIDTH+1:0] HALF = ONE >>> 1;

  // Two guard bits keep ONE/2 + x/4 from overflowing before the clamp.
  logic signed [WIDTH+1:0] xe;
  logic signed [WIDTH+1:0] p;

  assign xe = {{2{x[WIDTH-1]}}, x};

  always_comb begin
    p   = HALF + (xe >>> SIG_SHIFT);
    y   = x;
    sat = 1'b0;
    case (mode)
      MODE_SIGMOID: begin
        if (p[WIDTH+1]) begin
          y   = '0;
          sat = 1'b1;
        end else if (p > ONE) begin
          y   = ONE[WIDTH-1:0];
          sat = 1'b1;
        end else begin
          y = p[WIDTH-1:0];
        end
      end
      MODE_RELU: begin
        if (x[WIDTH-1]) y = '0;
      end
      MODE_LEAKY: begin
        if (x[WIDTH-1]) y = x >>> LEAKY_SHIFT;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane activation pipeline with saturation counter; 2-cycle latency, one beat per cycle.
// Backpressure: both stages advance only when the output register is empty or being taken.
module activation_unit
  import activation_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 11,
  parameter int LANES     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic [1:0]             s_mode,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*WIDTH-1:0] m_data,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_cnt
);

  localparam int SAT_W = $clog2(LANES + 1);

  typedef struct packed {
    logic                   vld;
    mode_e                  mode;
    logic [LANES*WIDTH-1:0] dat;
  } s1_t;

  logic                   en;
  s1_t                    s1;
  logic [LANES*WIDTH-1:0] lane_y;
  logic [LANES-1:0]       lane_sat;
  logic [SAT_W-1:0]       beat_sat;
  logic [SAT_W-1:0]       s2_sat;
  logic [CNT_W:0]         cnt_sum;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1.vld  <= s_valid;
      s1.mode <= mode_e'(s_mode);
      s1.dat  <= s_data;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .WIDTH    (WIDTH),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .x   (s1.dat[i*WIDTH +: WIDTH]),
      .mode(s1.mode),
      .y   (lane_y[i*WIDTH +: WIDTH]),
      .sat (lane_sat[i])
    );
  end

  always_comb begin
    beat_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sat = beat_sat + SAT_W'(lane_sat[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      s2_sat  <= '0;
    end else if (en) begin
      m_valid <= s1.vld;
      m_data  <= lane_y;
      s2_sat  <= beat_sat;
    end
  end

  // One extra bit catches the carry so the counter pins at all-ones instead of wrapping.
  assign cnt_sum = {1'b0, sat_cnt} + (CNT_W+1)'(s2_sat);

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt <= '0;
    end else if (m_valid && m_ready) begin
      sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: latency, per-mode arithmetic, streaming with stalls,
// saturation-counter clipping and clear priority, and mid-stream reset.
module tb_activation_unit;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*WIDTH-1:0] s_data;
  logic [1:0]             s_mode;
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*WIDTH-1:0] m_data;
  logic                   sat_clr;
  logic [CNT_W-1:0]       sat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  activation_unit #(
    .WIDTH    (WIDTH),
    .FRAC_BITS(11),
    .LANES    (LANES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_mode (s_mode),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .sat_clr(sat_clr),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic int lane_val(input int beat, input int lane);
    return -12000 + beat * 2500 + lane * 3000;
  endfunction

  // Reference: integer arithmetic on each lane, result truncated back to 16 bits.
  function automatic logic [63:0] model(input logic [63:0] d, input logic [1:0] m, output int nsat);
    logic [63:0] r;
    int x, y, p;
    r    = '0;
    nsat = 0;
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(d[i*WIDTH +: WIDTH]));
      case (m)
        2'd0: begin
          p = 1024 + (x >>> 2);
          if (p < 0) begin y = 0; nsat++; end
          else if (p > 2048) begin y = 2048; nsat++; end
          else y = p;
        end
        2'd1: y = (x < 0) ? 0 : x;
        2'd2: y = (x < 0) ? (x >>> 3) : x;
        default: y = x;
      endcase
      r[i*WIDTH +: WIDTH] = 16'(y);
    end
    return r;
  endfunction

  // Single beat with m_ready held high: checks the 2-cycle latency, result and counter update.
  task automatic run_beat(input string tag, input logic [63:0] d, input logic [1:0] m,
                          input logic [63:0] exp_d, input int exp_cnt, input bit clr_at_out);
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = m;
    m_ready = 1'b1;
    sat_clr = 1'b0;
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    chk({tag, "_lat1_vld"}, 64'(m_valid), 64'd0);
    step();
    chk({tag, "_lat2_vld"}, 64'(m_valid), 64'd1);
    chk({tag, "_data"}, m_data, exp_d);
    if (clr_at_out) sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk({tag, "_cnt"}, 64'(sat_cnt), 64'(exp_cnt));
    chk({tag, "_drain_vld"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] held;
    logic [63:0] beat_d;
    bit          stalled;
    int          sent, got, exp_sat, ns;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 2'd0;
    m_ready = 1'b0;
    sat_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    // Per-mode arithmetic and clamp boundaries.
    run_beat("sig_pos", pk(0, 2048, 4096, 8192), 2'd0, pk(1024, 1536, 2048, 2048), 1, 1'b0);
    run_beat("sig_neg", pk(-4096, -8192, -4096, -4096), 2'd0, pk(0, 0, 0, 0), 2, 1'b0);
    run_beat("leaky", pk(-8, -1, 5, 0), 2'd2, pk(-1, -1, 5, 0), 2, 1'b0);
    run_beat("relu", pk(-8, -1, 5, 0), 2'd1, pk(0, 0, 5, 0), 2, 1'b0);
    run_beat("bypass", pk(-32768, 32767, -1, 1234), 2'd3, pk(-32768, 32767, -1, 1234), 2, 1'b0);

    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("clr_idle", 64'(sat_cnt), 64'd0);

    // Ten beats, modes cycling per beat, random downstream stalls.
    sent    = 0;
    got     = 0;
    exp_sat = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = (sent < 10);
      s_data  = pk(lane_val(sent, 0), lane_val(sent, 1), lane_val(sent, 2), lane_val(sent, 3));
      s_mode  = 2'(sent % 4);
      #1;
      if (stalled) begin
        chk("stall_vld", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, held);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", 64'd1, 64'd0);
        end else begin
          chk("stream_data", m_data, exp_q.pop_front());
        end
        got++;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (s_valid && s_ready) begin
        beat_d = model(s_data, s_mode, ns);
        exp_q.push_back(beat_d);
        exp_sat += ns;
        sent++;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("stream_got", 64'(got), 64'd10);
    chk("stream_left", 64'(exp_q.size()), 64'd0);
    chk("stream_sat", 64'(sat_cnt), 64'((exp_sat > 15) ? 15 : exp_sat));

    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;

    // Counter clips at all-ones, then clear wins over a same-cycle increment.
    run_beat("clip4", pk(8192, 8192, 8192, 8192), 2'd0, pk(2048, 2048, 2048, 2048), 4, 1'b0);
    run_beat("clip8", pk(8192, 8192, 8192, 8192), 2'd0, pk(2048, 2048, 2048, 2048), 8, 1'b0);
    run_beat("clip12", pk(8192, 8192, 8192, 8192), 2'd0, pk(2048, 2048, 2048, 2048), 12, 1'b0);
    run_beat("clip15", pk(8192, 8192, 8192, 8192), 2'd0, pk(2048, 2048, 2048, 2048), 15, 1'b0);
    run_beat("clip_hold", pk(-32768, 8192, 8192, 8192), 2'd0, pk(0, 2048, 2048, 2048), 15, 1'b0);
    run_beat("clr_prio", pk(8192, 8192, 8192, 8192), 2'd0, pk(2048, 2048, 2048, 2048), 0, 1'b1);

    // Reset with two beats in flight and downstream stalled.
    run_beat("pre_rst", pk(8192, 8192, 8192, 8192), 2'd0, pk(2048, 2048, 2048, 2048), 4, 1'b0);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = pk(100, 200, 300, 400);
    s_mode  = 2'd3;
    step();
    s_data = pk(8192, 8192, 8192, 8192);
    s_mode = 2'd0;
    step();
    s_valid = 1'b0;
    chk("inflight_vld", 64'(m_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b1;
    step();
    chk("midrst_no_ghost1", 64'(m_valid), 64'd0);
    step();
    chk("midrst_no_ghost2", 64'(m_valid), 64'd0);
    chk("midrst_cnt_hold", 64'(sat_cnt), 64'd0);
    run_beat("post_rst", pk(0, 2048, 4096, 8192), 2'd0, pk(1024, 1536, 2048, 2048), 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the signed two's-complement sample width.
REQ-002 The block SHALL have parameter FRAC_BITS, default 11, meaning the fractional bits, so 1.0 = 2^FRAC_BITS (2048 at default).
REQ-003 The block SHALL have parameter LANES, default 4, meaning the number of samples per beat.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the saturation-counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit: input beat accepted when high with s_valid.
REQ-009 The block SHALL have port s_data, input, LANES*WIDTH bits: lane i at bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port s_mode, input, 2 bits: per-beat function select (0 hard-sigmoid, 1 ReLU, 2 leaky ReLU, 3 bypass).
REQ-011 The block SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: downstream accepts the beat.
REQ-013 The block SHALL have port m_data, output, LANES*WIDTH bits: results in the same lane order as s_data.
REQ-014 The block SHALL have port sat_clr, input, 1 bit: synchronous clear of sat_cnt.
REQ-015 The block SHALL have port sat_cnt, output, CNT_W bits: saturating count of clamped lanes.

Function
REQ-016 Hard-sigmoid SHALL compute p = ONE/2 + (x >>> 2) in WIDTH+2 bits, clamped to [0, ONE].
REQ-017 ReLU SHALL output x when x >= 0 and 0 otherwise.
REQ-018 Leaky ReLU SHALL output x when x >= 0 and x >>> 3 (arithmetic, floor) otherwise.
REQ-019 Bypass SHALL output x unchanged.
REQ-020 A lane SHALL count as saturated only in mode 0 when p < 0 or p > ONE; p equal to 0 or ONE is not saturated.
REQ-021 The pipeline SHALL have two register stages: stage 1 captures input and mode, stage 2 holds the result and the per-beat saturated-lane count.
REQ-022 Latency SHALL be exactly 2 cycles from the input handshake to m_valid with no stalls.
REQ-023 Throughput SHALL be one beat per cycle while m_ready is high.
REQ-024 Advance enable SHALL be en = !m_valid | m_ready, s_ready SHALL equal en, and both stages SHALL move only when en is high.
REQ-025 An empty stage SHALL propagate as a bubble; s_ready SHALL not depend combinationally on s_valid.
REQ-026 m_data and m_valid SHALL hold stable while m_valid & !m_ready.
REQ-027 On each output handshake, sat_cnt SHALL add that beat's saturated-lane count (0..LANES), clipping at 2^CNT_W-1 with no wrap.
REQ-028 sat_clr SHALL have priority over a simultaneous increment: sat_cnt becomes 0 and that beat's count is discarded.
REQ-029 The mode SHALL travel with its beat, so mode changes between consecutive beats take effect per beat with no flush.

Reset
REQ-030 On rst, stage valids, m_valid, m_data, the stage registers and sat_cnt SHALL clear to 0 on the next edge.
REQ-031 rst mid-stream SHALL drop all in-flight beats without producing an output handshake; s_ready SHALL be 1 in the cycle after reset.

Structure
REQ-032 Package activation_pkg SHALL hold the mode encodings (MODE_SIGMOID, MODE_RELU, MODE_LEAKY, MODE_BYPASS) and the shift constants (2 and 3).
REQ-033 Per-lane arithmetic SHALL live in combinational sub-module act_lane (x, mode -> y, sat), instantiated LANES times with generate.

Verification
REQ-034 Mode 0 with lanes {0, 2048, 4096, 8192} SHALL give {1024, 1536, 2048, 2048} with sat_cnt incrementing by 1.
REQ-035 Mode 0 with lanes {-4096, -8192} SHALL give {0, 0} with 1 saturation counted.
REQ-036 Mode 2 with lanes {-8, -1, 5, 0} SHALL give {-1, -1, 5, 0}; mode 1 with the same lanes SHALL give {0, 0, 5, 0}.
REQ-037 Ten back-to-back beats with alternating modes and m_ready toggled randomly SHALL arrive in order and unmodified, each output with its own mode, with no loss or duplication, and m_data stable while stalled.
REQ-038 sat_cnt preset near 2^CNT_W-1 followed by saturating beats SHALL hold at all-ones; sat_clr in the same cycle as a saturating handshake SHALL give 0.
REQ-039 rst asserted with two beats in flight SHALL give m_valid=0 and sat_cnt=0 on the next edge, followed by normal 2-cycle latency.
